draw_player: RTL and testbench

- Pixel-stream rendering stage placed directly downstream of the player movement controller (draw_player_ctl).
- Consumes the controller's xpos_player, ypos_player and state outputs and overlays an animated player sprite onto the incoming VGA timing/RGB stream.
- The sprite is procedural (no ROM): head, body and two-frame walking legs, plus an eye marking the facing direction.
- Sits between the background/level-drawing stage and the VGA output register.

---
 rtl/state_pkg.sv | 4 +
 rtl/draw_player.sv | 179 +++++++++++++++++
 tb/tb_draw_player.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/state_pkg.sv
// Movement states shared by draw_player_ctl and draw_player.
package state_pkg;
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} State;
endpackage

// File: rtl/draw_player.sv
// Player sprite overlay: 2-clk pipeline compositing a procedural walking sprite onto VGA.
// Optional DRAW_PLAYER_BBOX_EN draws a red bounding-box outline for collision debugging.
module draw_player
  import state_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned HEIGHT   = 48,
  parameter int unsigned Y_BASE   = 500,
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_player,
  input  logic [11:0] ypos_player,
  input  State        state,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam int unsigned CntW = $clog2(ANIM_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(ANIM_DIV - 1);

  localparam logic [12:0] W     = 13'(WIDTH);
  localparam logic [12:0] H     = 13'(HEIGHT);
  localparam logic [12:0] YB    = 13'(Y_BASE);
  localparam logic [12:0] HQ1   = 13'(HEIGHT / 4);
  localparam logic [12:0] HQ3   = 13'(3 * HEIGHT / 4);
  localparam logic [12:0] WQ1   = 13'(WIDTH / 4);
  localparam logic [12:0] WQ3   = 13'(3 * WIDTH / 4);
  localparam logic [12:0] WE3   = 13'(3 * WIDTH / 8);
  localparam logic [12:0] WE5   = 13'(5 * WIDTH / 8);
  localparam logic [12:0] EyeR  = 13'(WIDTH - 6);

  // Frame snapshot
  logic [11:0]     snap_x_q, snap_x_d;
  logic [11:0]     snap_y_q, snap_y_d;
  logic            snap_valid_q, snap_valid_d;
  logic            facing_right_q, facing_right_d;
  logic [1:0]      pose_q, pose_d;
  logic [CntW-1:0] anim_cnt_q, anim_cnt_d;

  // Stage 1
  logic [10:0] vcount_q, hcount_q;
  logic        vsync_q, hsync_q, vblnk_q, hblnk_q;
  logic [11:0] rgb_q;
  logic        in_box_q, in_box_d;
  logic [12:0] rx_q, rx_d, ry_q, ry_d;

  logic [12:0] hx, vx, x0, top;
  logic [11:0] rgb_d;
  logic        eye, head, body, legs;

  always_comb begin
    snap_x_d       = snap_x_q;
    snap_y_d       = snap_y_q;
    snap_valid_d   = snap_valid_q;
    facing_right_d = facing_right_q;
    pose_d         = pose_q;
    anim_cnt_d     = anim_cnt_q;
    if (hcount_in == 11'd0 && vcount_in == 11'd0) begin
      snap_x_d     = xpos_player;
      snap_y_d     = ypos_player;
      snap_valid_d = 1'b1;
      if (state == RIGHT) facing_right_d = 1'b1;
      else if (state == LEFT) facing_right_d = 1'b0;
      if (state == IDLE) begin
        pose_d     = 2'd0;
        anim_cnt_d = '0;
      end else if (pose_q == 2'd0) begin
        // First walking frame shows immediately.
        pose_d     = 2'd1;
        anim_cnt_d = '0;
      end else if (anim_cnt_q == CntMax) begin
        pose_d     = (pose_q == 2'd1) ? 2'd2 : 2'd1;
        anim_cnt_d = '0;
      end else begin
        anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end
  end

  // 13-bit arithmetic so box edges past 4095 never wrap onto low rows/columns.
  always_comb begin
    hx       = {2'b00, hcount_in};
    vx       = {2'b00, vcount_in};
    x0       = {1'b0, snap_x_q};
    top      = YB + {1'b0, snap_y_q};
    in_box_d = snap_valid_q && (hx >= x0) && (hx < x0 + W) && (vx >= top) && (vx < top + H);
    rx_d     = hx - x0;
    ry_d     = vx - top;
  end

  always_comb begin
    eye  = (ry_q >= 13'd4) && (ry_q <= 13'd5) &&
           (facing_right_q ? (rx_q >= EyeR && rx_q <= EyeR + 13'd1)
                           : (rx_q >= 13'd4 && rx_q <= 13'd5));
    head = (ry_q < HQ1) && (rx_q >= WQ1) && (rx_q < WQ3);
    body = (ry_q >= HQ1) && (ry_q < HQ3);
    legs = (ry_q >= HQ3) && (((rx_q < WE3) && (pose_q != 2'd2)) ||
                             ((rx_q >= WE5) && (pose_q != 2'd1)));
    rgb_d = rgb_q;
    if (in_box_q && !hblnk_q && !vblnk_q) begin
`ifdef DRAW_PLAYER_BBOX_EN
      if (rx_q == 13'd0 || rx_q == W - 13'd1 || ry_q == 13'd0 || ry_q == H - 13'd1)
        rgb_d = 12'hF00;
      else
`endif
      if (eye) rgb_d = 12'h000;
      else if (head) rgb_d = 12'hFC9;
      else if (body) rgb_d = 12'h36F;
      else if (legs) rgb_d = 12'h333;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_x_q       <= '0;
      snap_y_q       <= '0;
      snap_valid_q   <= 1'b0;
      facing_right_q <= 1'b1;
      pose_q         <= 2'd0;
      anim_cnt_q     <= '0;
      vcount_q       <= '0;
      hcount_q       <= '0;
      vsync_q        <= 1'b0;
      hsync_q        <= 1'b0;
      vblnk_q        <= 1'b0;
      hblnk_q        <= 1'b0;
      rgb_q          <= '0;
      in_box_q       <= 1'b0;
      rx_q           <= '0;
      ry_q           <= '0;
      vcount_out     <= '0;
      hcount_out     <= '0;
      vsync_out      <= 1'b0;
      hsync_out      <= 1'b0;
      vblnk_out      <= 1'b0;
      hblnk_out      <= 1'b0;
      rgb_out        <= '0;
    end else begin
      snap_x_q       <= snap_x_d;
      snap_y_q       <= snap_y_d;
      snap_valid_q   <= snap_valid_d;
      facing_right_q <= facing_right_d;
      pose_q         <= pose_d;
      anim_cnt_q     <= anim_cnt_d;
      vcount_q       <= vcount_in;
      hcount_q       <= hcount_in;
      vsync_q        <= vsync_in;
      hsync_q        <= hsync_in;
      vblnk_q        <= vblnk_in;
      hblnk_q        <= hblnk_in;
      rgb_q          <= rgb_in;
      in_box_q       <= in_box_d;
      rx_q           <= rx_d;
      ry_q           <= ry_d;
      vcount_out     <= vcount_q;
      hcount_out     <= hcount_q;
      vsync_out      <= vsync_q;
      hsync_out      <= hsync_q;
      vblnk_out      <= vblnk_q;
      hblnk_out      <= hblnk_q;
      rgb_out        <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_player.sv
// Randomized bench for draw_player against a frame-level behavioural model of the sprite.
module tb_draw_player;
  import state_pkg::*;

  localparam int W  = 32;
  localparam int H  = 48;
  localparam int YB = 500;
  localparam int AD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos_player = '0;
  logic [11:0] ypos_player = '0;
  State        state = IDLE;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, hsync_in = 1'b0, vblnk_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
  logic [11:0] rgb_out;

  always #5 clk = ~clk;

  draw_player #(.WIDTH(W), .HEIGHT(H), .Y_BASE(YB), .ANIM_DIV(AD)) dut (
    .clk(clk), .rst(rst), .xpos_player(xpos_player), .ypos_player(ypos_player),
    .state(state), .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  typedef struct packed {
    logic [10:0] v;
    logic [10:0] h;
    logic        vs, hs, vb, hb;
    logic [11:0] rgb;
  } pix_t;

  pix_t pipe[$];
  int   vectors = 0;
  int   errors  = 0;

  // Stimulus knobs
  int   want_x = 0, want_y = 0;
  State want_state = IDLE;
  bit   noise = 1'b0;
  int   blank_pct = 12;

  // Model: what was seen at the last frame start
  int m_x, m_y, m_walk;
  bit m_right, m_valid;

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_walk = 0; m_right = 1'b1; m_valid = 1'b0;
  endfunction

  function automatic void model_snapshot();
    m_x = int'(xpos_player);
    m_y = int'(ypos_player);
    m_valid = 1'b1;
    if (state == RIGHT) m_right = 1'b1;
    else if (state == LEFT) m_right = 1'b0;
    m_walk = (state == IDLE) ? 0 : m_walk + 1;  // frames spent walking
  endfunction

  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb, logic [11:0] bg);
    int rx, ry, pose, eye_x;
    rx = h - m_x;
    ry = v - (YB + m_y);
    if (!m_valid || hb || vb || rx < 0 || rx >= W || ry < 0 || ry >= H) return bg;
    pose = (m_walk == 0) ? 0 : ((((m_walk - 1) / AD) % 2 == 0) ? 1 : 2);
`ifdef DRAW_PLAYER_BBOX_EN
    if (rx == 0 || rx == W - 1 || ry == 0 || ry == H - 1) return 12'hF00;
`endif
    eye_x = m_right ? W - 6 : 4;
    if (ry >= 4 && ry <= 5 && rx >= eye_x && rx <= eye_x + 1) return 12'h000;
    if (ry < H / 4) return (rx >= W / 4 && rx < 3 * W / 4) ? 12'hFC9 : bg;
    if (ry < 3 * H / 4) return 12'h36F;
    if (rx < 3 * W / 8 && pose != 2) return 12'h333;
    if (rx >= 5 * W / 8 && pose != 1) return 12'h333;
    return bg;
  endfunction

  function automatic string fmt(pix_t p);
    return $sformatf("v=%0d h=%0d vs=%0b hs=%0b vb=%0b hb=%0b rgb=%03h",
                     p.v, p.h, p.vs, p.hs, p.vb, p.hb, p.rgb);
  endfunction

  // Drives one pixel for one clock; returns the output due now and what the model expects.
  task automatic step(input int h, input int v, output pix_t want, output pix_t got,
                      output bit ok);
    bit   fs;
    pix_t e;
    fs = (h == 0) && (v == 0);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    hblnk_in  = ($urandom_range(99, 0) < blank_pct);
    vblnk_in  = ($urandom_range(99, 0) < blank_pct);
    rgb_in    = 12'($urandom);
    if (fs || !noise) begin
      xpos_player = 12'(want_x);
      ypos_player = 12'(want_y);
      state       = want_state;
    end else begin
      xpos_player = 12'($urandom);
      ypos_player = 12'($urandom);
      state       = State'($urandom_range(2, 0));
    end
    e.v = vcount_in; e.h = hcount_in; e.vs = vsync_in; e.hs = hsync_in;
    e.vb = vblnk_in; e.hb = hblnk_in;
    e.rgb = model_rgb(h, v, hblnk_in, vblnk_in, rgb_in);
    if (fs) model_snapshot();
    pipe.push_back(e);
    @(posedge clk);
    #1;
    ok = (pipe.size() >= 2);
    want = '0;
    if (ok) want = pipe.pop_front();
    got = {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out};
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    pipe.delete();
    pipe.push_back('0);  // stage 1 still holds reset values for one more cycle
    model_reset();
  endtask

  task automatic test_reset();
    pix_t got;
    rst = 1'b1;
    repeat (3) begin
      hcount_in = 11'($urandom); vcount_in = 11'($urandom); rgb_in = 12'($urandom);
      hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b1;
      @(posedge clk);
      #1;
      got = {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out, rgb_out};
      vectors++;
      if (got !== '0) begin
        errors++;
        $display("FAIL reset: got %s want all zero", fmt(got));
      end
    end
    rst = 1'b0;
    pipe.delete();
    pipe.push_back('0);
    model_reset();
  endtask

  task automatic test_first_frame();
    pix_t want, got; bit ok;
    want_x = 0; want_y = 0; want_state = IDLE; noise = 1'b0;
    step(0, 0, want, got, ok);
    for (int v = YB - 1; v <= YB + H; v++)
      for (int h = 0; h <= W + 1; h++) begin
        step(h, v, want, got, ok);
        if (ok) begin
          vectors++;
          if (got !== want) begin
            errors++; $display("FAIL first_frame: got %s want %s", fmt(got), fmt(want));
          end
        end
      end
  endtask

  task automatic test_idle_sprite();
    pix_t want, got; bit ok;
    want_x = 100; want_y = 0; want_state = IDLE; noise = 1'b1;
    step(0, 0, want, got, ok);
    for (int v = YB - 1; v <= YB + H; v++)
      for (int h = 99; h <= 100 + W; h++) begin
        step(h, v, want, got, ok);
        if (ok) begin
          vectors++;
          if (got !== want) begin
            errors++; $display("FAIL idle_sprite: got %s want %s", fmt(got), fmt(want));
          end
        end
      end
  endtask

  task automatic test_walk();
    pix_t want, got; bit ok;
    int ph[8] = '{105, 125, 126, 127, 116, 110, 1, 2};
    int pv[8] = '{540, 540, 504, 505, 505, 530, 1, 1};
    want_x = 100; want_y = 0; want_state = RIGHT; noise = 1'b1; blank_pct = 0;
    for (int f = 1; f <= 20; f++) begin
      step(0, 0, want, got, ok);
      for (int i = 0; i < 8; i++) begin
        step(ph[i], pv[i], want, got, ok);
        if (ok) begin
          vectors++;
          if (got !== want) begin
            errors++;
            $display("FAIL walk frame %0d: got %s want %s", f, fmt(got), fmt(want));
          end
        end
      end
    end
    blank_pct = 12;
  endtask

  task automatic test_turn();
    pix_t want, got; bit ok;
    State seq[3] = '{RIGHT, LEFT, IDLE};
    want_x = 100; want_y = 0; noise = 1'b1;
    for (int s = 0; s < 3; s++) begin
      want_state = seq[s];
      step(0, 0, want, got, ok);
      for (int v = YB - 1; v <= YB + H; v++)
        for (int h = 99; h <= 100 + W; h++) begin
          step(h, v, want, got, ok);
          if (ok) begin
            vectors++;
            if (got !== want) begin
              errors++;
              $display("FAIL turn %s: got %s want %s", seq[s].name(), fmt(got), fmt(want));
            end
          end
        end
    end
  endtask

  task automatic test_midframe_move();
    pix_t want, got; bit ok;
    want_x = 100; want_y = 0; want_state = IDLE; noise = 1'b0;
    for (int f = 0; f < 2; f++) begin
      step(0, 0, want, got, ok);
      for (int h = 0; h < 4; h++) step(h, 300, want, got, ok);
      want_x = 200;  // moves mid-frame; only the next frame may show it
      for (int v = YB - 1; v <= YB + H; v += 3)
        for (int h = 98; h <= 234; h++) begin
          step(h, v, want, got, ok);
          if (ok) begin
            vectors++;
            if (got !== want) begin
              errors++;
              $display("FAIL midframe frame %0d: got %s want %s", f, fmt(got), fmt(want));
            end
          end
        end
    end
  endtask

  task automatic test_right_edge();
    pix_t want, got; bit ok;
    want_x = 790; want_y = 0; want_state = RIGHT; noise = 1'b1;
    step(0, 0, want, got, ok);
    for (int v = YB - 1; v <= YB + H; v++)
      for (int i = 0; i < 22; i++) begin
        step((i < 15) ? 785 + i : i - 15, v, want, got, ok);
        if (ok) begin
          vectors++;
          if (got !== want) begin
            errors++; $display("FAIL right_edge: got %s want %s", fmt(got), fmt(want));
          end
        end
      end
  endtask

  task automatic test_high_y();
    pix_t want, got; bit ok;
    want_x = 0; want_y = 4000; want_state = IDLE; noise = 1'b1;
    step(0, 0, want, got, ok);
    for (int v = 400; v <= 460; v++)
      for (int h = 0; h <= 40; h++) begin
        step(h, v, want, got, ok);
        if (ok) begin
          vectors++;
          if (got !== want) begin
            errors++; $display("FAIL high_y: got %s want %s", fmt(got), fmt(want));
          end
        end
      end
  endtask

  task automatic test_mid_reset();
    pix_t want, got; bit ok;
    want_x = 300; want_y = 20; want_state = LEFT; noise = 1'b1;
    step(0, 0, want, got, ok);
    for (int h = 300; h < 332; h++) step(h, 530, want, got, ok);
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      if (f == 1) step(0, 0, want, got, ok);
      for (int v = YB + 19; v <= YB + 20 + H; v += 2)
        for (int h = 299; h <= 300 + W; h++) begin
          step(h, v, want, got, ok);
          if (ok) begin
            vectors++;
            if (got !== want) begin
              errors++;
              $display("FAIL mid_reset pass %0d: got %s want %s", f, fmt(got), fmt(want));
            end
          end
        end
    end
  endtask

  task automatic test_random();
    pix_t want, got; bit ok;
    noise = 1'b1;
    for (int f = 0; f < 4; f++) begin
      want_x = $urandom_range(780, 0);
      want_y = $urandom_range(40, 0);
      want_state = State'($urandom_range(2, 0));
      step(0, 0, want, got, ok);
      for (int v = YB + want_y - 1; v <= YB + want_y + H; v++)
        for (int h = (want_x > 0 ? want_x - 1 : 0); h <= want_x + W; h++) begin
          step(h, v, want, got, ok);
          if (ok) begin
            vectors++;
            if (got !== want) begin
              errors++; $display("FAIL random frame %0d: got %s want %s", f, fmt(got), fmt(want));
            end
          end
        end
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 1, want, got, ok);
      if (ok) begin
        vectors++;
        if (got !== want) begin
          errors++; $display("FAIL random flush: got %s want %s", fmt(got), fmt(want));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_frame();
    test_idle_sprite();
    test_walk();
    test_turn();
    test_midframe_move();
    test_right_edge();
    test_high_y();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
